// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter with a valid/ready word input and a
// framed serial output (q, q_valid, frame_start, done).
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             q,
    output logic             q_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             armed_q;

    logic             last_bit;
    logic             xfer;
    logic             out_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // armed_q keeps din_ready low until the first clock edge after reset release,
    // so no word can be taken on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign out_bit       = shreg_q[WIDTH-1];
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign out_bit       = shreg_q[0];
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit  = (state_q == SHIFT) && (cnt_q == '0);
    assign din_ready = armed_q && ((state_q == IDLE) || last_bit);
    assign xfer      = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = CNT_LAST;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q - 1'b1;
                end else if (xfer) begin
                    // Back-to-back word: reload without leaving SHIFT.
                    shreg_d = din;
                    cnt_d   = CNT_LAST;
                end else begin
                    state_d = IDLE;
                    shreg_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // All serial outputs decode from registered state only; din never reaches q
    // combinationally.
    assign q_valid     = (state_q == SHIFT);
    assign q           = (state_q == SHIFT) && out_bit;
    assign frame_start = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign done        = last_bit;

endmodule
